// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and sizing helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and unified-memory signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;

    logic              err;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ack,
        output d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output err
    );

    // Requesters plus memory side.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ack,
        input  d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  err
    );

endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// Combinational owner selection: D wins unless I has been starved to the limit.
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       starve_hit,
    output logic       grant_valid,
    output arb_owner_e grant_owner
);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_D;
        if (if_req && (!d_req || starve_hit)) begin
            grant_owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one access in flight,
// with D priority, I anti-starvation and an optional memory-ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                clrn,
    mem_port_arbiter_if.slave   bus
);

    localparam int BW          = DW / 8;
    localparam int SW          = cnt_width(STARVE_LIMIT);
    localparam int WW          = cnt_width(TIMEOUT);
    localparam int WAIT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_LAST_I);

    arb_state_e        state_q,      state_d;
    arb_owner_e        owner_q,      owner_d;
    logic              mem_we_q,     mem_we_d;
    logic [AW-1:0]     mem_addr_q,   mem_addr_d;
    logic [DW-1:0]     mem_wdata_q,  mem_wdata_d;
    logic [BW-1:0]     mem_be_q,     mem_be_d;
    logic [DW-1:0]     rdata_q,      rdata_d;
    logic              err_q,        err_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [WW-1:0]     wait_cnt_q,   wait_cnt_d;

    logic              starve_hit;
    logic              grant_valid;
    arb_owner_e        grant_owner;
    logic              timeout_hit;
    logic              resp;

    assign starve_hit = (starve_cnt_q == STARVE_MAX);

    arb_prio_pick u_pick (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .starve_hit  (starve_hit),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The counter holds the number of BUSY cycles already spent; this cycle is the last allowed one.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                err_d      = 1'b0;
                if (!bus.if_req) begin
                    starve_cnt_d = '0;
                end
                if (grant_valid) begin
                    state_d = ST_BUSY;
                    owner_d = grant_owner;
                    if (grant_owner == OWN_D) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_we ? bus.d_wdata : '0;
                        mem_be_d    = bus.d_we ? bus.d_be : '1;
                        if (bus.if_req && !starve_hit) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else begin
                        mem_we_d     = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = '0;
                        mem_be_d     = '1;
                        starve_cnt_d = '0;
                    end
                end
            end

            ST_BUSY: begin
                // A real ack in the final allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign resp          = (state_q == ST_RESP);
    assign bus.mem_req   = (state_q == ST_BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_ack    = resp && (owner_q == OWN_I);
    assign bus.d_ack     = resp && (owner_q == OWN_D);
    assign bus.if_rdata  = bus.if_ack ? rdata_q : '0;
    assign bus.d_rdata   = bus.d_ack ? rdata_q : '0;
    assign bus.err       = resp && err_q;

endmodule
